interboard_tx: RTL and testbench
================================

Name: interboard_tx

Overview:
- Transmit end of the board-to-board link used by the Bingo game FSMs.
- Accepts one control message (en flag, 3-bit message type, 5-bit number) from the local game FSM.
- Sends it bit-serially to the peer board over a 4-phase req/ack handshake.
- Pulses inter_ready when the peer has acknowledged every bit; the game FSM holds its SEND_* state until that pulse.

Parameters:
- SYNC_STAGES, 2: flip-flop stages on the incoming ack wire (minimum 2).
- TIMEOUT_CYCLES, 1000000: cycles allowed per handshake phase before the frame is aborted.

Ports:
- clk  input  1  system clock.
- rst  input  1  synchronous active-high reset.
- interboard_rst  input  1  synchronous active-high reset from the link; same effect as rst.
- transmit  input  1  send request; sampled in IDLE only.
- ctrl_en  input  1  message enable flag; captured with the frame.
- ctrl_msg_type  input  3  message type code from the shared message defines; captured.
- ctrl_number  input  5  number payload; captured.
- interboard_ack  input  1  peer acknowledge, asynchronous to clk.
- interboard_req  output  1  request strobe to peer.
- interboard_data  output  1  serial data bit to peer.
- inter_ready  output  1  one-cycle pulse: frame fully acknowledged.
- tx_busy  output  1  high from capture until return to IDLE.
- tx_error  output  1  one-cycle pulse: handshake timeout, frame aborted.

Behaviour:
- Reset (rst or interboard_rst, synchronous): all outputs 0, state IDLE, bit counter 0, timeout counter 0, synchronizer chain 0.
- Frame: 9 bits, sent MSB first: {ctrl_en, ctrl_msg_type[2:0], ctrl_number[4:0]}.
- Capture: in IDLE with transmit=1, latch the frame into the shift register, bit index = 0, go to SETUP, tx_busy=1 from the next cycle.
- transmit is ignored in every state other than IDLE. No queueing.
- ack_s is interboard_ack after SYNC_STAGES flops. All decisions use ack_s only.
- States:
  - IDLE: req=0, data=0.
  - SETUP: drive data = current bit, req=0. Wait for ack_s=0, then after at least one cycle go to REQ_HI. Data is stable one cycle before req rises.
  - REQ_HI: req=1, data held. On ack_s=1 go to REQ_LO.
  - REQ_LO: req=0, data held. On ack_s=0: if the last bit was sent, go to DONE; otherwise advance the bit index and go to SETUP.
  - DONE: inter_ready=1 for exactly one cycle, tx_busy=0 next cycle, go to IDLE.
- Timeout: the counter clears on every state change and increments while SETUP, REQ_HI or REQ_LO waits. At TIMEOUT_CYCLES-1:
  - pulse tx_error for one cycle;
  - force req=0 and go to IDLE;
  - inter_ready is not asserted.
- Ack already high at capture: SETUP waits for it to fall; req never rises while ack_s=1.
- Reset mid-frame: req drops on the next edge, no inter_ready, partial frame discarded. The peer recovers via its own interboard_rst.
- inter_ready and tx_error are never high in the same cycle.
- Lower bound per bit: 1 + 2*(SYNC_STAGES+1) cycles.

Optional Feature:
- Macro: INTERBOARD_PARITY_EN.
- Defined: a 10th bit is appended after ctrl_number[0]. It is even parity over the 9 payload bits (XOR of the payload). The frame length counter terminates at 10.
- Undefined: 9-bit frame, no parity logic.
- Port list is identical either way.

Decomposition:
- Message type codes (STATE_TURN, STATE_WIN, SEL_NUM, ...) and frame length stay in the shared message define file.
- Add shared defines: frame width 9 and parity width 1.
- One natural sub-module, sync_bit: a SYNC_STAGES-deep synchronizer with synchronous reset, reused by the receive side.
- The FSM, shift register and timeout counter stay in interboard_tx.

Test Plan:
- Loopback peer model (ack follows req after 3 cycles); transmit with en=1, type=3'b010, number=5'd17.
  - Captured serial stream is 1,0,1,0,1,0,0,0,1.
  - inter_ready pulses once; tx_busy drops the following cycle.
- transmit held high for 5 cycles and re-pulsed mid-frame.
  - Exactly one frame sent.
  - A second frame starts only after inter_ready, when transmit is still high in IDLE.
- Peer never raises ack, TIMEOUT_CYCLES=50.
  - tx_error pulses 50 cycles after req rose; req=0; no inter_ready; state IDLE.
- interboard_ack tied high at capture.
  - req stays 0 until ack is released.
  - After release, the frame completes normally.
- rst asserted during bit 4 of a frame.
  - req=0 and tx_busy=0 on the next edge; no inter_ready.
  - A new transmit then sends a complete, correct frame.
- With INTERBOARD_PARITY_EN, payload en=1, type=3'b111, number=5'd0 (4 ones).
  - 10 bits sent; last bit is 0.
  - With number=5'd1 instead, the last bit is 1.

Source files
------------

// File: rtl/interboard_tx_pkg.sv
// interboard_tx_pkg: shared definitions for the board-to-board link.
// Holds the message type codes used by the Bingo game FSMs, the frame
// geometry (payload width and parity width), the transmit FSM state type
// and the parity helper shared with the receive side.
package interboard_tx_pkg;

  // Message type codes carried in ctrl_msg_type.
  localparam logic [2:0] MsgNone      = 3'b000;
  localparam logic [2:0] MsgStateTurn = 3'b001;
  localparam logic [2:0] MsgStateWin  = 3'b010;
  localparam logic [2:0] MsgSelNum    = 3'b011;
  localparam logic [2:0] MsgStateLose = 3'b100;
  localparam logic [2:0] MsgRestart   = 3'b101;

  // Frame geometry: {en, msg_type[2:0], number[4:0]} plus optional parity.
  localparam int unsigned FrameWidth  = 9;
  localparam int unsigned ParityWidth = 1;

  typedef enum logic [2:0] {
    StIdle,
    StSetup,
    StReqHi,
    StReqLo,
    StDone
  } tx_state_e;

  // Even parity: the appended bit makes the total count of ones even.
  function automatic logic even_parity(input logic [FrameWidth-1:0] payload);
    return ^payload;
  endfunction

endpackage

// File: rtl/interboard_tx_sync_bit.sv
// interboard_tx_sync_bit: single-bit synchronizer for asynchronous link
// wires (the link's sync_bit, also used by the receive side).
// Ports:
//   clk  - destination clock
//   rst  - synchronous active-high reset, clears the whole chain
//   d    - asynchronous input
//   q    - input after STAGES flops (STAGES is clamped to at least 2)
module interboard_tx_sync_bit #(
  parameter int unsigned STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  localparam int unsigned Depth = (STAGES < 2) ? 2 : STAGES;

  logic [Depth-1:0] chain_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      chain_q <= '0;
    end else begin
      chain_q <= {chain_q[Depth-2:0], d};
    end
  end

  assign q = chain_q[Depth-1];

endmodule

// File: rtl/interboard_tx.sv
// interboard_tx: transmit end of the board-to-board link. Captures one
// control message and sends it MSB first over a 4-phase req/ack handshake,
// one bit per handshake, with a per-phase timeout.
// Ports:
//   clk, rst         - clock, synchronous active-high reset
//   interboard_rst   - link reset, same effect as rst
//   transmit         - send request, only honoured in IDLE
//   ctrl_en, ctrl_msg_type, ctrl_number - message fields, captured on send
//   interboard_ack   - peer acknowledge (asynchronous, synchronized here)
//   interboard_req   - request strobe to peer
//   interboard_data  - serial data bit to peer
//   inter_ready      - one-cycle pulse when the whole frame was acknowledged
//   tx_busy          - high from capture until back in IDLE
//   tx_error         - one-cycle pulse when a handshake phase timed out
// Build option: define INTERBOARD_PARITY_EN to append an even-parity bit
// after ctrl_number[0] (10-bit frame). The port list does not change.
module interboard_tx
  import interboard_tx_pkg::*;
#(
  parameter int unsigned SYNC_STAGES    = 2,
  parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       interboard_rst,
  input  logic       transmit,
  input  logic       ctrl_en,
  input  logic [2:0] ctrl_msg_type,
  input  logic [4:0] ctrl_number,
  input  logic       interboard_ack,
  output logic       interboard_req,
  output logic       interboard_data,
  output logic       inter_ready,
  output logic       tx_busy,
  output logic       tx_error
);

`ifdef INTERBOARD_PARITY_EN
  localparam int unsigned FrameLen = FrameWidth + ParityWidth;
`else
  localparam int unsigned FrameLen = FrameWidth;
`endif
  localparam int unsigned IdxW   = $clog2(FrameLen);
  localparam int unsigned TimerW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TimerW-1:0] TimerMax = TimerW'(TIMEOUT_CYCLES - 1);
  localparam logic [IdxW-1:0]   LastIdx  = IdxW'(FrameLen - 1);

  logic rst_any;
  logic ack_s;

  logic [FrameWidth-1:0] payload;
  logic [FrameLen-1:0]   frame_in;

  tx_state_e             state_q, state_d;
  logic [FrameLen-1:0]   shift_q, shift_d;
  logic [IdxW-1:0]       idx_q, idx_d;
  logic [TimerW-1:0]     timer_q, timer_d;
  logic                  tx_error_q, tx_error_d;

  logic waiting;
  logic last_bit;

  assign rst_any = rst | interboard_rst;

  interboard_tx_sync_bit #(
    .STAGES (SYNC_STAGES)
  ) u_ack_sync (
    .clk (clk),
    .rst (rst_any),
    .d   (interboard_ack),
    .q   (ack_s)
  );

  assign payload = {ctrl_en, ctrl_msg_type, ctrl_number};
`ifdef INTERBOARD_PARITY_EN
  assign frame_in = {payload, even_parity(payload)};
`else
  assign frame_in = payload;
`endif

  assign last_bit = (idx_q == LastIdx);

  // State register plus datapath registers.
  always_ff @(posedge clk) begin
    if (rst_any) begin
      state_q    <= StIdle;
      shift_q    <= '0;
      idx_q      <= '0;
      timer_q    <= '0;
      tx_error_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      idx_q      <= idx_d;
      timer_q    <= timer_d;
      tx_error_q <= tx_error_d;
    end
  end

  // Next-state logic. A timeout only fires while a phase is still stalled,
  // so progress on the final allowed cycle wins over the abort.
  always_comb begin
    state_d    = state_q;
    waiting    = 1'b0;
    tx_error_d = 1'b0;
    unique case (state_q)
      StIdle:  if (transmit) state_d = StSetup;
      // Leaving SETUP needs ack_s low, so req never rises over a stale ack;
      // the SETUP cycle itself gives data one cycle of lead over req.
      StSetup: if (!ack_s) state_d = StReqHi; else waiting = 1'b1;
      StReqHi: if (ack_s) state_d = StReqLo; else waiting = 1'b1;
      StReqLo: begin
        if (!ack_s) state_d = last_bit ? StDone : StSetup;
        else        waiting = 1'b1;
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
    if (waiting && (timer_q == TimerMax)) begin
      state_d    = StIdle;
      tx_error_d = 1'b1;
    end
  end

  // Shift register, bit index and per-phase timeout counter.
  always_comb begin
    shift_d = shift_q;
    idx_d   = idx_q;
    timer_d = '0;
    if ((state_q == StIdle) && transmit) begin
      shift_d = frame_in;
      idx_d   = '0;
    end else if ((state_q == StReqLo) && (state_d == StSetup)) begin
      shift_d = {shift_q[FrameLen-2:0], 1'b0};
      idx_d   = idx_q + 1'b1;
    end
    // Counter restarts on every state change.
    if (waiting && (state_d == state_q)) begin
      timer_d = timer_q + 1'b1;
    end
  end

  // Output logic.
  always_comb begin
    interboard_req  = 1'b0;
    interboard_data = 1'b0;
    inter_ready     = 1'b0;
    tx_busy         = (state_q != StIdle);
    tx_error        = tx_error_q;
    unique case (state_q)
      StSetup: interboard_data = shift_q[FrameLen-1];
      StReqHi: begin
        interboard_req  = 1'b1;
        interboard_data = shift_q[FrameLen-1];
      end
      StReqLo: interboard_data = shift_q[FrameLen-1];
      StDone:  inter_ready = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_interboard_tx.sv
// tb_interboard_tx: directed self-checking bench for interboard_tx with a
// peer model whose ack follows req after 3 cycles (or is forced low/high).
module tb_interboard_tx;

`ifdef INTERBOARD_PARITY_EN
  localparam int FLEN = 10;
`else
  localparam int FLEN = 9;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       interboard_rst = 1'b0;
  logic       transmit = 1'b0;
  logic       ctrl_en = 1'b0;
  logic [2:0] ctrl_msg_type = 3'b000;
  logic [4:0] ctrl_number = 5'd0;
  logic       interboard_ack;
  logic       interboard_req;
  logic       interboard_data;
  logic       inter_ready;
  logic       tx_busy;
  logic       tx_error;

  int asserts  = 0;
  int failures = 0;

  // 0: loopback, 1: ack stuck low, 2: ack stuck high.
  int peer_mode = 0;
  logic [2:0] req_dly = 3'b000;

  logic [15:0] cap_bits = '0;
  int cap_cnt = 0, ready_cnt = 0, err_cnt = 0, both_cnt = 0;
  int viol_cnt = 0, forced_req_cnt = 0;
  logic req_prev = 1'b0, data_prev = 1'b0;
  logic [9:0] fmask;

  interboard_tx #(
    .SYNC_STAGES    (2),
    .TIMEOUT_CYCLES (50)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .interboard_rst  (interboard_rst),
    .transmit        (transmit),
    .ctrl_en         (ctrl_en),
    .ctrl_msg_type   (ctrl_msg_type),
    .ctrl_number     (ctrl_number),
    .interboard_ack  (interboard_ack),
    .interboard_req  (interboard_req),
    .interboard_data (interboard_data),
    .inter_ready     (inter_ready),
    .tx_busy         (tx_busy),
    .tx_error        (tx_error)
  );

  always #5 clk = ~clk;

  always @(posedge clk) req_dly <= {req_dly[1:0], interboard_req};
  assign interboard_ack = (peer_mode == 2) ? 1'b1 : (peer_mode == 1) ? 1'b0 : req_dly[2];

  // Peer-side monitor: captures a bit on each req rising edge.
  always @(negedge clk) begin
    if (interboard_req && !req_prev) begin
      cap_bits <= {cap_bits[14:0], interboard_data};
      cap_cnt  <= cap_cnt + 1;
      if (interboard_data !== data_prev) viol_cnt <= viol_cnt + 1;
    end
    if (interboard_req && interboard_ack && peer_mode == 2) forced_req_cnt <= forced_req_cnt + 1;
    if (inter_ready) ready_cnt <= ready_cnt + 1;
    if (tx_error) err_cnt <= err_cnt + 1;
    if (inter_ready && tx_error) both_cnt <= both_cnt + 1;
    req_prev  <= interboard_req;
    data_prev <= interboard_data;
  end

  function automatic logic [9:0] exp_frame(input logic [8:0] p);
`ifdef INTERBOARD_PARITY_EN
    return {p, ^p};
`else
    return {1'b0, p};
`endif
  endfunction

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic cycles(input int n);
    repeat (n) tick();
  endtask

  task automatic send_pulse(input logic en, input logic [2:0] t, input logic [4:0] n);
    ctrl_en = en; ctrl_msg_type = t; ctrl_number = n;
    transmit = 1'b1;
    tick();
    transmit = 1'b0;
  endtask

  task automatic wait_ready(input int budget, output bit seen);
    seen = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (inter_ready) begin
        seen = 1'b1;
        break;
      end
      tick();
    end
  endtask

  task automatic test_reset();
    int r0;
    rst = 1'b1;
    cycles(3);
    asserts++; if (interboard_req !== 1'b0) begin failures++; $display("FAIL reset_req got %b exp 0", interboard_req); end
    asserts++; if (interboard_data !== 1'b0) begin failures++; $display("FAIL reset_data got %b exp 0", interboard_data); end
    asserts++; if (inter_ready !== 1'b0) begin failures++; $display("FAIL reset_ready got %b exp 0", inter_ready); end
    asserts++; if (tx_busy !== 1'b0) begin failures++; $display("FAIL reset_busy got %b exp 0", tx_busy); end
    asserts++; if (tx_error !== 1'b0) begin failures++; $display("FAIL reset_error got %b exp 0", tx_error); end
    rst = 1'b0;
    cycles(3);
    // Link reset mid-frame behaves like rst.
    r0 = ready_cnt;
    send_pulse(1'b1, 3'b011, 5'd4);
    cycles(10);
    asserts++; if (tx_busy !== 1'b1) begin failures++; $display("FAIL ibrst_busy_before got %b exp 1", tx_busy); end
    interboard_rst = 1'b1;
    tick();
    interboard_rst = 1'b0;
    asserts++; if (interboard_req !== 1'b0 || tx_busy !== 1'b0) begin
      failures++; $display("FAIL ibrst_idle got req=%b busy=%b exp 0/0", interboard_req, tx_busy);
    end
    cycles(12);
    asserts++; if (ready_cnt != r0) begin failures++; $display("FAIL ibrst_no_ready got %0d exp %0d", ready_cnt, r0); end
  endtask

  task automatic test_basic();
    int r0, c0;
    bit seen;
    r0 = ready_cnt; c0 = cap_cnt;
    send_pulse(1'b1, 3'b010, 5'd17);
    asserts++; if (tx_busy !== 1'b1) begin failures++; $display("FAIL basic_busy_start got %b exp 1", tx_busy); end
    wait_ready(1000, seen);
    asserts++; if (!seen) begin failures++; $display("FAIL basic_ready_seen got 0 exp 1"); end
    asserts++; if (tx_busy !== 1'b1) begin failures++; $display("FAIL basic_busy_at_ready got %b exp 1", tx_busy); end
    tick();
    asserts++; if (inter_ready !== 1'b0 || tx_busy !== 1'b0) begin
      failures++; $display("FAIL basic_after_ready got ready=%b busy=%b exp 0/0", inter_ready, tx_busy);
    end
    asserts++; if (cap_cnt - c0 != FLEN) begin failures++; $display("FAIL basic_bitcount got %0d exp %0d", cap_cnt - c0, FLEN); end
    asserts++; if ((cap_bits[9:0] & fmask) !== exp_frame(9'b1_010_10001)) begin
      failures++; $display("FAIL basic_stream got %b exp %b", cap_bits[9:0] & fmask, exp_frame(9'b1_010_10001));
    end
    asserts++; if (ready_cnt - r0 != 1) begin failures++; $display("FAIL basic_ready_count got %0d exp 1", ready_cnt - r0); end
    asserts++; if (viol_cnt != 0) begin failures++; $display("FAIL basic_data_setup got %0d exp 0", viol_cnt); end
  endtask

  task automatic test_hold();
    int r0, c0;
    bit seen;
    r0 = ready_cnt; c0 = cap_cnt;
    ctrl_en = 1'b0; ctrl_msg_type = 3'b011; ctrl_number = 5'd9;
    transmit = 1'b1;
    cycles(5);
    transmit = 1'b0;
    cycles(20);
    transmit = 1'b1;
    cycles(2);
    transmit = 1'b0;
    wait_ready(1000, seen);
    asserts++; if (!seen) begin failures++; $display("FAIL hold_ready_seen got 0 exp 1"); end
    cycles(21);
    asserts++; if (cap_cnt - c0 != FLEN) begin failures++; $display("FAIL hold_one_frame got %0d bits exp %0d", cap_cnt - c0, FLEN); end
    asserts++; if (ready_cnt - r0 != 1) begin failures++; $display("FAIL hold_ready_count got %0d exp 1", ready_cnt - r0); end
    asserts++; if ((cap_bits[9:0] & fmask) !== exp_frame(9'b0_011_01001)) begin
      failures++; $display("FAIL hold_stream got %b exp %b", cap_bits[9:0] & fmask, exp_frame(9'b0_011_01001));
    end
    asserts++; if (tx_busy !== 1'b0) begin failures++; $display("FAIL hold_idle got %b exp 0", tx_busy); end
    // transmit held through DONE: the next frame starts from IDLE.
    r0 = ready_cnt; c0 = cap_cnt;
    transmit = 1'b1;
    wait_ready(1000, seen);
    asserts++; if (!seen) begin failures++; $display("FAIL b2b_ready1_seen got 0 exp 1"); end
    tick();
    asserts++; if (tx_busy !== 1'b0) begin failures++; $display("FAIL b2b_idle_gap got %b exp 0", tx_busy); end
    tick();
    asserts++; if (tx_busy !== 1'b1) begin failures++; $display("FAIL b2b_recapture got %b exp 1", tx_busy); end
    transmit = 1'b0;
    wait_ready(1000, seen);
    asserts++; if (!seen) begin failures++; $display("FAIL b2b_ready2_seen got 0 exp 1"); end
    cycles(21);
    asserts++; if (cap_cnt - c0 != 2 * FLEN) begin failures++; $display("FAIL b2b_bits got %0d exp %0d", cap_cnt - c0, 2 * FLEN); end
    asserts++; if (ready_cnt - r0 != 2) begin failures++; $display("FAIL b2b_ready_count got %0d exp 2", ready_cnt - r0); end
  endtask

  task automatic test_timeout();
    int r0, e0, k;
    bit seen;
    peer_mode = 1;
    cycles(3);
    r0 = ready_cnt; e0 = err_cnt;
    send_pulse(1'b1, 3'b100, 5'd3);
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (interboard_req) begin seen = 1'b1; break; end
      tick();
    end
    asserts++; if (!seen) begin failures++; $display("FAIL timeout_req_rise got 0 exp 1"); end
    k = 0;
    while (!tx_error && k < 200) begin
      tick();
      k++;
    end
    asserts++; if (k != 50) begin failures++; $display("FAIL timeout_latency got %0d exp 50", k); end
    asserts++; if (interboard_req !== 1'b0 || tx_busy !== 1'b0 || inter_ready !== 1'b0) begin
      failures++; $display("FAIL timeout_abort got req=%b busy=%b ready=%b exp 0/0/0", interboard_req, tx_busy, inter_ready);
    end
    tick();
    asserts++; if (tx_error !== 1'b0) begin failures++; $display("FAIL timeout_pulse_width got %b exp 0", tx_error); end
    asserts++; if (err_cnt - e0 != 1) begin failures++; $display("FAIL timeout_err_count got %0d exp 1", err_cnt - e0); end
    asserts++; if (ready_cnt != r0) begin failures++; $display("FAIL timeout_no_ready got %0d exp %0d", ready_cnt, r0); end
    peer_mode = 0;
    cycles(5);
  endtask

  task automatic test_ack_high();
    int f0, c0;
    bit seen;
    peer_mode = 2;
    cycles(5);
    f0 = forced_req_cnt; c0 = cap_cnt;
    send_pulse(1'b0, 3'b110, 5'd21);
    cycles(20);
    asserts++; if (tx_busy !== 1'b1) begin failures++; $display("FAIL ackhi_busy got %b exp 1", tx_busy); end
    asserts++; if (forced_req_cnt != f0 || interboard_req !== 1'b0) begin
      failures++; $display("FAIL ackhi_req_held got %0d cycles of req exp 0", forced_req_cnt - f0);
    end
    peer_mode = 0;
    wait_ready(1000, seen);
    asserts++; if (!seen) begin failures++; $display("FAIL ackhi_ready_seen got 0 exp 1"); end
    tick();
    asserts++; if (cap_cnt - c0 != FLEN) begin failures++; $display("FAIL ackhi_bits got %0d exp %0d", cap_cnt - c0, FLEN); end
    asserts++; if ((cap_bits[9:0] & fmask) !== exp_frame(9'b0_110_10101)) begin
      failures++; $display("FAIL ackhi_stream got %b exp %b", cap_bits[9:0] & fmask, exp_frame(9'b0_110_10101));
    end
  endtask

  task automatic test_reset_mid();
    int r0, c0;
    bit seen;
    r0 = ready_cnt; c0 = cap_cnt;
    send_pulse(1'b1, 3'b001, 5'd30);
    seen = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      if (cap_cnt - c0 == 5) begin seen = 1'b1; break; end
      tick();
    end
    asserts++; if (!seen || interboard_req !== 1'b1) begin
      failures++; $display("FAIL rstmid_bit4 got reached=%0d req=%b exp 1/1", seen, interboard_req);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    asserts++; if (interboard_req !== 1'b0 || tx_busy !== 1'b0 || inter_ready !== 1'b0) begin
      failures++; $display("FAIL rstmid_idle got req=%b busy=%b ready=%b exp 0/0/0", interboard_req, tx_busy, inter_ready);
    end
    cycles(12);
    asserts++; if (ready_cnt != r0) begin failures++; $display("FAIL rstmid_no_ready got %0d exp %0d", ready_cnt, r0); end
    c0 = cap_cnt;
    send_pulse(1'b0, 3'b101, 5'd6);
    wait_ready(1000, seen);
    asserts++; if (!seen) begin failures++; $display("FAIL rstmid_ready_seen got 0 exp 1"); end
    tick();
    asserts++; if (cap_cnt - c0 != FLEN) begin failures++; $display("FAIL rstmid_bits got %0d exp %0d", cap_cnt - c0, FLEN); end
    asserts++; if ((cap_bits[9:0] & fmask) !== exp_frame(9'b0_101_00110)) begin
      failures++; $display("FAIL rstmid_stream got %b exp %b", cap_bits[9:0] & fmask, exp_frame(9'b0_101_00110));
    end
  endtask

`ifdef INTERBOARD_PARITY_EN
  task automatic test_parity();
    int c0;
    bit seen;
    c0 = cap_cnt;
    send_pulse(1'b1, 3'b111, 5'd0);
    wait_ready(1000, seen);
    tick();
    asserts++; if (!seen || cap_cnt - c0 != 10) begin failures++; $display("FAIL parity_len got %0d exp 10", cap_cnt - c0); end
    asserts++; if (cap_bits[0] !== 1'b0) begin failures++; $display("FAIL parity_even got %b exp 0", cap_bits[0]); end
    send_pulse(1'b1, 3'b111, 5'd1);
    wait_ready(1000, seen);
    tick();
    asserts++; if (cap_bits[0] !== 1'b1) begin failures++; $display("FAIL parity_odd got %b exp 1", cap_bits[0]); end
  endtask
`endif

  task automatic test_exclusive();
    asserts++; if (both_cnt != 0) begin failures++; $display("FAIL ready_error_overlap got %0d exp 0", both_cnt); end
    asserts++; if (viol_cnt != 0) begin failures++; $display("FAIL data_lead got %0d exp 0", viol_cnt); end
  endtask

  initial begin
    fmask = 10'((1 << FLEN) - 1);
    test_reset();
    test_basic();
    test_hold();
    test_timeout();
    test_ack_high();
    test_reset_mid();
`ifdef INTERBOARD_PARITY_EN
    test_parity();
`endif
    test_exclusive();
    $display("End of test - %0d assertions evaluated, %0d failures", asserts, failures);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1);
  end

endmodule
